tristate_bus_arbiter: RTL and testbench

Shares one tristate output pin between REQUESTERS internal sources. Grants are round-robin. A guaranteed turnaround gap, with the pin released (hi-Z), separates any two drivers. The block produces the registered enable/value pair that feeds the tristate_output instance for the pin, so no two sources ever drive back-to-back without a gap.

---
 rtl/tristate_arb_pkg.sv | 23 ++
 rtl/tristate_bus_arbiter_rr_pick.sv | 29 ++
 rtl/tristate_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tristate_arb_pkg.sv
// rtl/tristate_arb_pkg.sv - shared state encoding and counter width helpers for the tristate bus arbiter
package tristate_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // Ceiling log2, never below 1 so index vectors always have a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  // Width of a counter that must represent 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return clog2(n + 1);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// rtl/tristate_bus_arbiter_rr_pick.sv - combinational round-robin picker searching upward from last_owner+1
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx
);

  // First set request after the pointer wins; the pointer itself is checked last.
  always_comb begin
    logic found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 1; i <= int'(N); i++) begin
      int k;
      k = (int'(last_owner) + i) % int'(N);
      if (!found && req[k]) begin
        found     = 1'b1;
        win_oh[k] = 1'b1;
        win_idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner of one tristate pin with turnaround gaps; TRISTATE_ARB_PARK_EN parks the idle pin
module tristate_bus_arbiter
  import tristate_arb_pkg::*;
#(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned MAX_HOLD   = 16,
  parameter logic        PARK_VALUE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTERS-1:0] req,
  input  logic [REQUESTERS-1:0] val,
  output logic [REQUESTERS-1:0] grant,
  output logic                  out_enable,
  output logic                  out_value,
  output logic                  busy
);

  localparam int unsigned IW = clog2(REQUESTERS);
  localparam int unsigned HW = cnt_width(MAX_HOLD);
  localparam int unsigned TW = cnt_width(TURNAROUND);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(REQUESTERS - 1);

  arb_state_t              state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic                    out_enable_q, out_enable_d;
  logic                    out_value_q, out_value_d;
  logic                    busy_q, busy_d;
  logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]           turn_cnt_q, turn_cnt_d;
  logic [IW-1:0]           last_owner_q, last_owner_d;

  logic [REQUESTERS-1:0]   win_oh;
  logic [IW-1:0]           win_idx;
  logic                    take;
  logic [REQUESTERS-1:0]   take_oh;
  logic [IW-1:0]           take_idx;
  logic                    preempt;

`ifdef TRISTATE_ARB_PARK_EN
  logic                    pend_valid_q, pend_valid_d;
  logic [REQUESTERS-1:0]   pend_oh_q, pend_oh_d;
  logic [IW-1:0]           pend_idx_q, pend_idx_d;
`else
  logic                    unused_park;
  assign unused_park = PARK_VALUE;
`endif

  rr_pick #(.N(REQUESTERS), .IW(IW)) u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .win_oh     (win_oh),
    .win_idx    (win_idx)
  );

  // Another requester waiting once the owner has used its full hold budget.
  always_comb begin
    preempt = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && ((req & ~grant_q) != '0);
  end

  // Next-state logic: arbitrate in IDLE or final TURN cycle, release into TURN, count the gap.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    out_enable_d = out_enable_q;
    out_value_d  = out_value_q;
    busy_d       = busy_q;
    hold_cnt_d   = hold_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    last_owner_d = last_owner_q;
    take         = 1'b0;
    take_oh      = win_oh;
    take_idx     = win_idx;
`ifdef TRISTATE_ARB_PARK_EN
    pend_valid_d = pend_valid_q;
    pend_oh_d    = pend_oh_q;
    pend_idx_d   = pend_idx_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef TRISTATE_ARB_PARK_EN
        if (req != '0) begin
          state_d      = TURN;
          out_enable_d = 1'b0;
          busy_d       = 1'b1;
          turn_cnt_d   = TURN_LOAD;
          pend_valid_d = 1'b1;
          pend_oh_d    = win_oh;
          pend_idx_d   = win_idx;
        end else begin
          out_enable_d = 1'b1;
          out_value_d  = PARK_VALUE;
        end
`else
        take = (req != '0);
`endif
      end
      DRIVE: begin
        out_value_d = val[last_owner_q];
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        if (!req[last_owner_q] || preempt) begin
          state_d      = TURN;
          grant_d      = '0;
          out_enable_d = 1'b0;
          turn_cnt_d   = TURN_LOAD;
        end
      end
      TURN: begin
        if (turn_cnt_q != '0) begin
          turn_cnt_d = turn_cnt_q - 1'b1;
`ifdef TRISTATE_ARB_PARK_EN
        end else if (pend_valid_q) begin
          take         = 1'b1;
          take_oh      = pend_oh_q;
          take_idx     = pend_idx_q;
          pend_valid_d = 1'b0;
`endif
        end else if (req != '0) begin
          take = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take) begin
      state_d      = DRIVE;
      grant_d      = take_oh;
      last_owner_d = take_idx;
      out_enable_d = 1'b1;
      out_value_d  = val[take_idx];
      hold_cnt_d   = '0;
      busy_d       = 1'b1;
    end
  end

  // State register; reset drops the pin immediately with no turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      out_enable_q <= 1'b0;
      out_value_q  <= 1'b0;
      busy_q       <= 1'b0;
      hold_cnt_q   <= '0;
      turn_cnt_q   <= '0;
      last_owner_q <= LAST_INIT;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      out_enable_q <= out_enable_d;
      out_value_q  <= out_value_d;
      busy_q       <= busy_d;
      hold_cnt_q   <= hold_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef TRISTATE_ARB_PARK_EN
  // Winner chosen on leaving the parked IDLE, held until the gap completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_oh_q    <= '0;
      pend_idx_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_oh_q    <= pend_oh_d;
      pend_idx_q   <= pend_idx_d;
    end
  end
`endif

  assign grant      = grant_q;
  assign out_enable = out_enable_q;
  assign out_value  = out_value_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - directed self-checking bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] val;
  logic [3:0] grant;
  logic       out_enable;
  logic       out_value;
  logic       busy;

  int total;
  int bad;

  tristate_bus_arbiter #(
    .REQUESTERS (4),
    .TURNAROUND (2),
    .MAX_HOLD   (16),
    .PARK_VALUE (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .val        (val),
    .grant      (grant),
    .out_enable (out_enable),
    .out_value  (out_value),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check n consecutive cycles of one expected owner (0 = gap), advancing one cycle after each.
  task automatic phase(input string tag, input logic [3:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_en"}, 32'(out_enable), 32'(|g));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (g != 4'b0000) chk({tag, "_val"}, 32'(out_value), 32'(|(val & g)));
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b1111;
    val   = 4'b0001;

`ifdef TRISTATE_ARB_PARK_EN
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_en", 32'(out_enable), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
    end
    rst = 1'b0;
    step();
    chk("park_en", 32'(out_enable), 32'd1);
    chk("park_val", 32'(out_value), 32'd1);
    chk("park_busy", 32'(busy), 32'd0);
    req = 4'b0010;
    val = 4'b0010;
    step();
    chk("leave_en0", 32'(out_enable), 32'd0);
    chk("leave_busy", 32'(busy), 32'd1);
    chk("leave_grant", 32'(grant), 32'd0);
    step();
    chk("leave_en1", 32'(out_enable), 32'd0);
    step();
    chk("park_grant", 32'(grant), 32'h2);
    chk("park_drive_en", 32'(out_enable), 32'd1);
    chk("park_drive_val", 32'(out_value), 32'd1);
    req = 4'b0000;
    step();
    chk("rel_en0", 32'(out_enable), 32'd0);
    step();
    step();
    chk("reidle_busy", 32'(busy), 32'd0);
    chk("reidle_en", 32'(out_enable), 32'd0);
    step();
    chk("repark_en", 32'(out_enable), 32'd1);
    chk("repark_val", 32'(out_value), 32'd1);
`else
    // Reset held with all requests pending.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_en", 32'(out_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    step();
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_en", 32'(out_enable), 32'd1);
    chk("first_val", 32'(out_value), 32'd1);
    chk("first_busy", 32'(busy), 32'd1);

    // val[0] follows to the pin with one cycle of lag.
    req = 4'b0001;
    val = 4'b0000;
    step();
    chk("lag_val0", 32'(out_value), 32'd0);
    val = 4'b0001;
    step();
    chk("lag_val1", 32'(out_value), 32'd1);
    val = 4'b0000;
    step();
    chk("lag_val2", 32'(out_value), 32'd0);

    // Release with nothing else pending: two-cycle gap then IDLE.
    req = 4'b0000;
    step();
    chk("gap1_en", 32'(out_enable), 32'd0);
    chk("gap1_grant", 32'(grant), 32'd0);
    chk("gap1_busy", 32'(busy), 32'd1);
    step();
    chk("gap2_en", 32'(out_enable), 32'd0);
    chk("gap2_busy", 32'(busy), 32'd1);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_en", 32'(out_enable), 32'd0);

    // Two simultaneous requests alternate through preemption, pointer fresh from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0101;
    val = 4'b0001;
    step();
    phase("rr_a", 4'b0001, 16);
    phase("rr_gap1", 4'b0000, 2);
    phase("rr_b", 4'b0100, 16);
    phase("rr_gap2", 4'b0000, 2);
    phase("rr_c", 4'b0001, 1);
    req = 4'b0000;
    step();
    step();
    step();
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // req[2] joins at DRIVE cycle 3; owner 0 still gets 16 cycles total.
    req = 4'b0001;
    val = 4'b0100;
    step();
    phase("pre_a0", 4'b0001, 2);
    req = 4'b0101;
    phase("pre_a1", 4'b0001, 14);
    phase("pre_gap1", 4'b0000, 2);
    phase("pre_b", 4'b0100, 16);
    phase("pre_gap2", 4'b0000, 2);
    phase("pre_c", 4'b0001, 1);
    req = 4'b0000;
    step();
    step();
    step();
    chk("pre_idle_busy", 32'(busy), 32'd0);

    // Reset mid-DRIVE drops the pin at once.
    req = 4'b0010;
    step();
    chk("mid_grant", 32'(grant), 32'h2);
    rst = 1'b1;
    step();
    chk("mid_rst_en", 32'(out_enable), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);

    // Fresh pointer picks lowest index; handoff at the final TURN cycle.
    rst = 1'b0;
    req = 4'b1010;
    step();
    chk("ptr_grant", 32'(grant), 32'h2);
    req = 4'b1000;
    step();
    chk("hand_en0", 32'(out_enable), 32'd0);
    step();
    chk("hand_en1", 32'(out_enable), 32'd0);
    step();
    chk("hand_grant", 32'(grant), 32'h8);
    chk("hand_en2", 32'(out_enable), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
